shift_mix_cols: RTL and testbench



---
 rtl/aes_pkg.sv | 57 +++++
 rtl/shift_mix_cols_if.sv | 30 +++
 rtl/shift_mix_cols_mix_column.sv | 41 ++++
 rtl/shift_mix_cols.sv | 107 ++++++++++
 tb/tb_shift_mix_cols.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES round definitions: byte/column/state types, FSM encoding and GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int         BYTE_SIZE = 8;
    localparam int         NUM_COLS  = 4;
    localparam logic [7:0] GF_POLY   = 8'h1B;

    typedef logic [BYTE_SIZE-1:0] byte_t;
    // Column c of the state: bytes 4c..4c+3, row 0 in the most significant byte.
    typedef byte_t [0:3]          col_t;
    // Packed so that state[0][0] lands on bits [127:120] of a 128-bit vector.
    typedef col_t [0:NUM_COLS-1]  state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b this folds to a few xtime/XOR terms.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < BYTE_SIZE; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotated left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < NUM_COLS; c++)
            for (int w = 0; w < 4; w++)
                r[c][w] = s[2'(c + w)][w];
        return r;
    endfunction

    // Row r rotated right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < NUM_COLS; c++)
            for (int w = 0; w < 4; w++)
                r[c][w] = s[2'(c - w + NUM_COLS)][w];
        return r;
    endfunction

endpackage

// File: rtl/shift_mix_cols_if.sv
// Block-level bus for shift_mix_cols: input handshake + state, output handshake + state, busy.
// Latency: n/a (wiring only). Optional inv signal present when AES_INV_CIPHER_EN is defined.
// Backpressure: valid/ready on both sides; slave modport is the stage, master is the driver.
interface shift_mix_cols_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_state;
    logic                  last_round;
`ifdef AES_INV_CIPHER_EN
    logic                  inv;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_state;
    logic                  busy;

`ifdef AES_INV_CIPHER_EN
    modport master (output in_valid, in_state, last_round, inv, out_ready,
                    input  in_ready, out_valid, out_state, busy);
    modport slave  (input  in_valid, in_state, last_round, inv, out_ready,
                    output in_ready, out_valid, out_state, busy);
`else
    modport master (output in_valid, in_state, last_round, out_ready,
                    input  in_ready, out_valid, out_state, busy);
    modport slave  (input  in_valid, in_state, last_round, out_ready,
                    output in_ready, out_valid, out_state, busy);
`endif
endinterface

// File: rtl/shift_mix_cols_mix_column.sv
// mix_column: combinational (Inv)MixColumns of one 32-bit column, row 0 in the top byte.
// Latency: 0 cycles. Ports: col_in, col_out, plus inv when AES_INV_CIPHER_EN is defined.
// Backpressure: none (pure function).
module mix_column
    import aes_pkg::*;
(
`ifdef AES_INV_CIPHER_EN
    input  logic inv,
`endif
    input  col_t col_in,
    output col_t col_out
);

    byte_t k0, k1, k2, k3;

    // Coefficients of matrix row 0; row r uses the same set rotated right by r.
    always_comb begin
        k0 = 8'h02;
        k1 = 8'h03;
        k2 = 8'h01;
        k3 = 8'h01;
`ifdef AES_INV_CIPHER_EN
        if (inv) begin
            k0 = 8'h0e;
            k1 = 8'h0b;
            k2 = 8'h0d;
            k3 = 8'h09;
        end
`endif
    end

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++)
            col_out[r] = gf_mul(col_in[r],          k0) ^
                         gf_mul(col_in[2'(r + 1)], k1) ^
                         gf_mul(col_in[2'(r + 2)], k2) ^
                         gf_mul(col_in[2'(r + 3)], k3);
    end

endmodule

// File: rtl/shift_mix_cols.sv
// ShiftRows + iterative MixColumns (one column/cycle); ports clk, rst_n, bus (slave). Optional AES_INV_CIPHER_EN adds decrypt.
// Latency: 5 cycles accept->out_valid (1 cycle when last_round bypasses MixColumns); one block in flight.
// Backpressure: in_ready only in IDLE; result held stable in HOLD until out_ready.
module shift_mix_cols
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int COLS       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_mix_cols_if.slave bus
);

    fsm_t   state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    state_t work, work_nxt;
    state_t in_s;
    state_t mixed;
    col_t   mix_out;
`ifdef AES_INV_CIPHER_EN
    logic   inv_q, inv_nxt;
`endif

    assign in_s = bus.in_state;

    mix_column u_mix (
`ifdef AES_INV_CIPHER_EN
        .inv     (inv_q),
`endif
        .col_in  (work[cnt]),
        .col_out (mix_out)
    );

    always_comb begin
        mixed      = work;
        mixed[cnt] = mix_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
`ifdef AES_INV_CIPHER_EN
            inv_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
`ifdef AES_INV_CIPHER_EN
            inv_q <= inv_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
`ifdef AES_INV_CIPHER_EN
        inv_nxt   = inv_q;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_nxt = '0;
`ifdef AES_INV_CIPHER_EN
                    inv_nxt = bus.inv;
                    // Decrypt mixes the raw state and un-shifts on the way into HOLD.
                    if (bus.last_round) begin
                        state_nxt = HOLD;
                        work_nxt  = bus.inv ? inv_shift_rows(in_s) : shift_rows(in_s);
                    end else begin
                        state_nxt = MIX;
                        work_nxt  = bus.inv ? in_s : shift_rows(in_s);
                    end
`else
                    state_nxt = bus.last_round ? HOLD : MIX;
                    work_nxt  = shift_rows(in_s);
`endif
                end
            end
            MIX: begin
                cnt_nxt  = cnt + 2'd1;
                work_nxt = mixed;
                if (cnt == 2'(COLS - 1)) begin
                    state_nxt = HOLD;
`ifdef AES_INV_CIPHER_EN
                    if (inv_q) work_nxt = inv_shift_rows(mixed);
`endif
                end
            end
            HOLD: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_state = work;

endmodule

// File: tb/tb_shift_mix_cols.sv
module tb_shift_mix_cols;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_mix_cols_if #(.DATA_WIDTH(128)) bus ();

    shift_mix_cols #(.DATA_WIDTH(128), .COLS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         last;
        logic         inv;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] R1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_in(input logic [127:0] d, input logic last, input logic inv);
        bus.in_state   = d;
        bus.last_round = last;
`ifdef AES_INV_CIPHER_EN
        bus.inv        = inv;
`else
        if (inv) $display("note: inv vector in encrypt-only build");
`endif
    endtask

    // Offers one block, waits (bounded) for the result; out_ready must already be 1.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " in_ready before"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        drive_in(v.din, v.last, v.inv);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_state = ~v.din;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check({v.name, " latency"}, 128'(lat), 128'(v.lat));
        check({v.name, " out_state"}, bus.out_state, v.dout);
        @(negedge clk);
        check({v.name, " in_ready after"}, 128'(bus.in_ready), 128'(1));
        check({v.name, " out_valid after"}, 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs.push_back('{"round1",   R1_IN, 1'b0, 1'b0, R1_OUT, 5});
        vecs.push_back('{"lastrnd",  R1_IN, 1'b1, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1});
        vecs.push_back('{"onecol",   128'hdb000000001300000000530000000045, 1'b0, 1'b0,
                         128'h8e4da1bc000000000000000000000000, 5});
        vecs.push_back('{"onecol_l", 128'hdb000000001300000000530000000045, 1'b1, 1'b0,
                         128'hdb135345000000000000000000000000, 1});
        vecs.push_back('{"zeros",    128'h0, 1'b0, 1'b0, 128'h0, 5});
        vecs.push_back('{"ones",     {16{8'h01}}, 1'b0, 1'b0, {16{8'h01}}, 5});
        vecs.push_back('{"c6",       {16{8'hc6}}, 1'b0, 1'b0, {16{8'hc6}}, 5});
`ifdef AES_INV_CIPHER_EN
        vecs.push_back('{"inv_rnd",  R1_OUT, 1'b0, 1'b1, R1_IN, 5});
        vecs.push_back('{"inv_last", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b1, R1_IN, 1});
`endif

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_in(128'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready",  128'(bus.in_ready),  128'(1));
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset out_state", bus.out_state,       128'h0);
        check("reset busy",      128'(bus.busy),      128'(0));
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held for 10 cycles while new offers are refused.
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        drive_in(R1_IN, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check("bp latency", 128'(lat), 128'(5));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_state   = {$urandom, $urandom, $urandom, $urandom};
            bus.last_round = 1'b1;
            @(negedge clk);
            check("bp out_valid", 128'(bus.out_valid), 128'(1));
            check("bp out_state", bus.out_state,       R1_OUT);
            check("bp in_ready",  128'(bus.in_ready),  128'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp release in_ready",  128'(bus.in_ready),  128'(1));
        check("bp release out_valid", 128'(bus.out_valid), 128'(0));
        check("bp release busy",      128'(bus.busy),      128'(0));
        check("bp release out_state", bus.out_state,       R1_OUT);

        // Reset while in MIX with the column counter at 2.
        @(negedge clk);
        bus.in_valid = 1'b1;
        drive_in(R1_IN, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid busy", 128'(bus.busy), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst in_ready",  128'(bus.in_ready),  128'(1));
        check("midrst out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst out_state", bus.out_state,       128'h0);
        check("midrst busy",      128'(bus.busy),      128'(0));
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
